// File: rtl/bounce_sprite_engine.sv
// Bouncing-ball sprite engine: a once-per-frame motion update walks the balls
// one per cycle, while every pixel is coloured ball/shadow/background.
module bounce_sprite_engine #(
    parameter int         NUM_BALLS    = 2,
    parameter int         BALL_R       = 20,
    parameter int         SHADOW_W     = 4,
    parameter int         SPEED        = 2,
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter logic [5:0] BALL_COLOR   = 6'b11_10_00,
    parameter logic [5:0] SHADOW_COLOR = 6'b01_01_01,
    parameter logic [5:0] BG_COLOR     = 6'b00_00_10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       pause,
    output logic [5:0] rgb,
    output logic       frame_done,
    output logic [7:0] bounce_cnt,
    output logic       collide
);
    localparam logic [9:0]  X_HI    = 10'(H_ACTIVE - 1 - BALL_R);
    localparam logic [9:0]  Y_HI    = 10'(V_ACTIVE - 1 - BALL_R);
    localparam logic [9:0]  LO      = 10'(BALL_R);
    localparam logic [10:0] LO_TRIG = 11'(BALL_R + SPEED);
    localparam logic [10:0] STEP11  = 11'(SPEED);
    localparam logic [9:0]  STEP10  = 10'(SPEED);
    localparam logic [21:0] CORE_R2 = 22'(BALL_R * BALL_R);
    localparam logic [21:0] SHAD_R2 = 22'((BALL_R + SHADOW_W) * (BALL_R + SHADOW_W));
    localparam logic [1:0]  K_LAST  = 2'(NUM_BALLS - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           k_q, k_d;
    logic                 frame_start;
    logic [NUM_BALLS-1:0] core;
    logic [NUM_BALLS-1:0] shadow;
    logic [NUM_BALLS-1:0][1:0] bounce_inc;
    logic [7:0]           bounce_sum;
    logic [2:0]           hit_cnt;
    logic                 hit;
    logic [5:0]           rgb_q, rgb_d;
    logic [7:0]           bounce_q, bounce_d;
    logic                 collide_q, collide_d;
    logic                 sticky_q, sticky_d;

    // Returns {new_pos, new_dir, bounced}; positions clamp at the walls, never wrap.
    function automatic logic [11:0] step_axis(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] hi);
        logic [10:0] up;
        logic [11:0] r;
        up = {1'b0, pos} + STEP11;
        if (dir) begin
            if (up >= {1'b0, hi}) r = {hi, 1'b0, 1'b1};
            else                  r = {up[9:0], 1'b1, 1'b0};
        end else begin
            if ({1'b0, pos} < LO_TRIG) r = {LO, 1'b1, 1'b1};
            else                       r = {pos - STEP10, 1'b0, 1'b0};
        end
        return r;
    endfunction

    assign frame_start = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));

    for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : gen_ball
        logic [9:0]         x_q, x_d, y_q, y_d;
        logic               dx_q, dx_d, dy_q, dy_d;
        logic [11:0]        x_step, y_step;
        logic [1:0]         inc;
        logic               sel;
        logic signed [10:0] dxp, dyp;
        logic signed [21:0] sqx, sqy;
        logic [21:0]        d2;

        assign sel    = (state_q == UPDATE) && (k_q == 2'(gi));
        assign x_step = step_axis(x_q, dx_q, X_HI);
        assign y_step = step_axis(y_q, dy_q, Y_HI);

        always_comb begin
            x_d  = x_q;
            y_d  = y_q;
            dx_d = dx_q;
            dy_d = dy_q;
            inc  = 2'd0;
            if (sel) begin
                x_d  = x_step[11:2];
                dx_d = x_step[1];
                y_d  = y_step[11:2];
                dy_d = y_step[1];
                inc  = {1'b0, x_step[0]} + {1'b0, y_step[0]};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                x_q  <= 10'(BALL_R + 64 + 128 * gi);
                y_q  <= 10'(BALL_R + 40 + 80 * gi);
                dx_q <= ((gi % 2) == 0);
                dy_q <= 1'b1;
            end else begin
                x_q  <= x_d;
                y_q  <= y_d;
                dx_q <= dx_d;
                dy_q <= dy_d;
            end
        end

        // Products of an 11-bit signed value with itself are non-negative and below 2^21.
        assign dxp    = $signed({1'b0, hpos}) - $signed({1'b0, x_q});
        assign dyp    = $signed({1'b0, vpos}) - $signed({1'b0, y_q});
        assign sqx    = dxp * dxp;
        assign sqy    = dyp * dyp;
        assign d2     = $unsigned(sqx) + $unsigned(sqy);
        assign core[gi]       = (d2 <= CORE_R2);
        assign shadow[gi]     = (d2 <= SHAD_R2);
        assign bounce_inc[gi] = inc;
    end

    always_comb begin
        bounce_sum = 8'd0;
        hit_cnt    = 3'd0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            bounce_sum = bounce_sum + 8'(bounce_inc[i]);
            hit_cnt    = hit_cnt + 3'(core[i]);
        end
    end

    assign hit = display_on && (hit_cnt >= 3'd2);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (frame_start && !pause) begin
                    state_d = UPDATE;
                    k_d     = 2'd0;
                end
            end
            UPDATE: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    k_d     = 2'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (!display_on)  rgb_d = 6'd0;
        else if (|core)   rgb_d = BALL_COLOR;
        else if (|shadow) rgb_d = SHADOW_COLOR;
        else              rgb_d = BG_COLOR;

        bounce_d  = bounce_q + bounce_sum;
        sticky_d  = sticky_q | hit;
        collide_d = collide_q;
        // The overlap seen during the finished frame is published and a new one begins.
        if (frame_start) begin
            collide_d = sticky_q;
            sticky_d  = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= 2'd0;
            rgb_q     <= 6'd0;
            bounce_q  <= 8'd0;
            collide_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rgb_q     <= rgb_d;
            bounce_q  <= bounce_d;
            collide_q <= collide_d;
            sticky_q  <= sticky_d;
        end
    end

    assign rgb        = rgb_q;
    assign frame_done = (state_q == DONE);
    assign bounce_cnt = bounce_q;
    assign collide    = collide_q;

endmodule
